// File: rtl/jt201d_uart_spi_bridge.sv
// UART ASCII command frames -> one 33-bit SPI transaction each; reads reply as hex over UART.
// Optional macro JT_WRITE_ACK_EN: writes are acknowledged with "K\n" on the UART.
module jt201d_uart_spi_bridge #(
    parameter int CLKS_PER_BIT = 573,
    parameter int SPI_DIV      = 4
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_uart_rx,
    output logic o_uart_tx,
    output logic o_ld_parity,
    output logic o_SCLK,
    output logic o_MOSI,
    input  logic i_MISO,
    output logic o_SEN
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int DW = $clog2(SPI_DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_HUNT, P_CMD, P_COL1, P_ADDR, P_COL2, P_DATA, P_RUN} p_state_e;
    typedef enum logic [1:0] {R_LOW, R_HIGH, R_TAIL, R_TX} r_state_e;

    rx_state_e rx_state_q, rx_state_d;
    p_state_e  p_state_q, p_state_d;
    r_state_e  r_state_q, r_state_d;

    logic [2:0]    rx_sync_q, rx_sync_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d, dig_q, dig_d, tx_idx_q, tx_idx_d, tx_last_q, tx_last_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic          rx_vld_q, rx_vld_d, rw_q, rw_d;
    logic [11:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [DW-1:0] spi_cnt_q, spi_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [32:0]   shreg_q, shreg_d;
    logic [19:0]   rdata_q, rdata_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, sen_q, sen_d, parity_q, parity_d, tx_q, tx_d;
    logic [3:0]    tx_bit_q, tx_bit_d, nib;
    logic [7:0]    tx_char;
    logic [9:0]    tx_frame;
    logic [4:0]    hx;
    logic          rx, rx_prev;

    // {valid, nibble}; letters map via low nibble + 9 for both cases
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)                                  return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, 4'(c[3:0] + 4'd9)};
        else                                                           return 5'd0;
    endfunction

    assign rx       = rx_sync_q[1];
    assign rx_prev  = rx_sync_q[2];
    assign hx       = hex_dec(rx_byte_q);
    assign tx_frame = {1'b1, tx_char, 1'b0};

    always_comb begin
        case (tx_idx_q)
            3'd0:    nib = rdata_q[19:16];
            3'd1:    nib = rdata_q[15:12];
            3'd2:    nib = rdata_q[11:8];
            3'd3:    nib = rdata_q[7:4];
            default: nib = rdata_q[3:0];
        endcase
        if (tx_idx_q == tx_last_q) tx_char = 8'h0A;
        else if (!rw_q)            tx_char = 8'h4B;
        else                       tx_char = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    end

    always_comb begin
        rx_sync_d  = {rx_sync_q[1:0], i_uart_rx};
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        rx_byte_d  = rx_byte_q;
        p_state_d  = p_state_q;
        rw_d       = rw_q;
        dig_d      = dig_q;
        addr_d     = addr_q;
        data_d     = data_q;
        r_state_d  = r_state_q;
        spi_cnt_d  = spi_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rdata_d    = rdata_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        sen_d      = sen_q;
        parity_d   = parity_q;
        tx_d       = 1'b1;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_last_d  = tx_last_q;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx && rx_prev) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            default: if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                rx_state_d = RX_IDLE;
                if (rx) begin
                    rx_vld_d  = 1'b1;
                    rx_byte_d = rx_shift_q;
                end
            end
        endcase

        if (rx_vld_q && p_state_q != P_RUN) begin
            if (rx_byte_q == 8'h7B) p_state_d = P_CMD;
            else case (p_state_q)
                P_CMD: begin
                    rw_d      = (rx_byte_q == 8'h41);
                    p_state_d = (rx_byte_q == 8'h41 || rx_byte_q == 8'h61) ? P_COL1 : P_HUNT;
                end
                P_COL1, P_COL2: begin
                    dig_d     = '0;
                    p_state_d = (rx_byte_q != 8'h3A) ? P_HUNT : (p_state_q == P_COL1) ? P_ADDR : P_DATA;
                end
                P_ADDR: begin
                    addr_d = {addr_q[7:0], hx[3:0]};
                    dig_d  = dig_q + 1'b1;
                    if (!hx[4])             p_state_d = P_HUNT;
                    else if (dig_q == 3'd2) p_state_d = P_COL2;
                end
                P_DATA: begin
                    data_d = {data_q[11:0], hx[3:0]};
                    dig_d  = dig_q + 1'b1;
                    if (!hx[4]) p_state_d = P_HUNT;
                    else if (dig_q == 3'd4) begin
                        p_state_d = P_RUN;
                        r_state_d = R_LOW;
                        spi_cnt_d = '0;
                        bit_cnt_d = '0;
                        shreg_d   = {rw_q, addr_q, rw_q ? 20'd0 : {data_q, hx[3:0]}};
                        sen_d     = 1'b0;
                        mosi_d    = rw_q;
                    end
                end
                default: ;
            endcase
        end

        // R_LOW doubles as the SEN-to-first-rise lead time
        if (p_state_q == P_RUN) begin
            case (r_state_q)
                R_LOW: if (spi_cnt_q == DW'(SPI_DIV - 1)) begin
                    spi_cnt_d = '0;
                    sclk_d    = 1'b1;
                    r_state_d = R_HIGH;
                    if (bit_cnt_q >= 6'd13) rdata_d = {rdata_q[18:0], i_MISO};
                end
                R_HIGH: if (spi_cnt_q == DW'(SPI_DIV - 1)) begin
                    spi_cnt_d = '0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 6'd32) r_state_d = R_TAIL;
                    else begin
                        shreg_d   = {shreg_q[31:0], 1'b0};
                        mosi_d    = shreg_q[31];
                        r_state_d = R_LOW;
                    end
                end
                R_TAIL: if (spi_cnt_q == DW'(SPI_DIV - 1)) begin
                    sen_d    = 1'b1;
                    mosi_d   = 1'b0;
                    tx_idx_d = '0;
                    tx_bit_d = '0;
                    tx_cnt_d = '0;
                    if (rw_q) begin
                        parity_d  = ^rdata_q;
                        tx_last_d = 3'd5;
                        r_state_d = R_TX;
                    end else begin
`ifdef JT_WRITE_ACK_EN
                        tx_last_d = 3'd1;
                        r_state_d = R_TX;
`else
                        p_state_d = P_HUNT;
`endif
                    end
                end
                default: begin
                    tx_d = tx_frame[tx_bit_q];
                    if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt_d = '0;
                        tx_bit_d = tx_bit_q + 1'b1;
                        if (tx_bit_q == 4'd9) begin
                            tx_bit_d = '0;
                            tx_idx_d = tx_idx_q + 1'b1;
                            if (tx_idx_q == tx_last_q) p_state_d = P_HUNT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_vld_q   <= 1'b0;
            rx_byte_q  <= '0;
            p_state_q  <= P_HUNT;
            rw_q       <= 1'b0;
            dig_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            r_state_q  <= R_LOW;
            spi_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rdata_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            sen_q      <= 1'b1;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_last_q  <= '0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_vld_q   <= rx_vld_d;
            rx_byte_q  <= rx_byte_d;
            p_state_q  <= p_state_d;
            rw_q       <= rw_d;
            dig_q      <= dig_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            r_state_q  <= r_state_d;
            spi_cnt_q  <= spi_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rdata_q    <= rdata_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            sen_q      <= sen_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign o_uart_tx   = tx_q;
    assign o_ld_parity = parity_q;
    assign o_SCLK      = sclk_q;
    assign o_MOSI      = mosi_q;
    assign o_SEN       = sen_q;
endmodule

// File: tb/tb_jt201d_uart_spi_bridge.sv
// Bench for jt201d_uart_spi_bridge: frame table with SPI/UART scoreboards plus reset-abort sequence.
module tb_jt201d_uart_spi_bridge;
    localparam int CPB = 16;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, miso = 1'b0;
    logic tx, par, sclk, mosi, sen;
    always #5 clk = ~clk;

    jt201d_uart_spi_bridge #(.CLKS_PER_BIT(CPB), .SPI_DIV(4)) dut (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(rx), .o_uart_tx(tx),
        .o_ld_parity(par), .o_SCLK(sclk), .o_MOSI(mosi), .i_MISO(miso), .o_SEN(sen)
    );

    int total = 0, bad = 0;
    logic [32:0] exp_spi_q[$];
    logic [7:0]  exp_tx_q[$];
    int          miso_mode = 0;
    logic [19:0] miso_word = 20'h12345;
    bit          spi_ignore = 1'b0;

    typedef struct {
        string       cmd;
        bit          has_spi;
        logic [32:0] spi;
        string       reply;
        int          mode;    // 0: MISO=0, 1: MISO=1, 2: MISO plays miso_word
        logic        par;
    } vec_t;
    vec_t vecs[8];

    function automatic vec_t mk(input string c, input bit h, input logic [32:0] s,
                                input string r, input int m, input logic p);
        vec_t v;
        v.cmd = c; v.has_spi = h; v.spi = s; v.reply = r; v.mode = m; v.par = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // SPI slave model and MOSI scoreboard
    logic        sclk_p = 1'b0, sen_p = 1'b1;
    logic [32:0] sh = '0;
    int          pulses = 0;
    always @(negedge clk) begin
        if (!sen && sen_p) begin
            sh = '0;
            pulses = 0;
        end
        if (!sen && sclk && !sclk_p) begin
            sh = {sh[31:0], mosi};
            pulses++;
        end
        if (!sen && !sclk && sclk_p && miso_mode == 2 && pulses >= 13 && pulses <= 32)
            miso = miso_word[32 - pulses];
        if (sen && !sen_p && !spi_ignore) begin
            if (exp_spi_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spi_unexpected actual=%0h required=none", sh);
            end else begin
                check("spi_mosi", 64'(sh), 64'(exp_spi_q.pop_front()));
                check("spi_pulses", 64'(pulses), 64'd33);
            end
        end
        sclk_p = sclk;
        sen_p  = sen;
    end

    // UART reply decoder and byte scoreboard
    initial begin : txmon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (exp_tx_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected actual=%0h required=none", b);
                end else begin
                    check("tx_byte", 64'(b), 64'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string wack;
        bit    idle_ok;
        int    n;
`ifdef JT_WRITE_ACK_EN
        wack = "K\n";
`else
        wack = "";
`endif
        vecs[0] = mk("t",                1'b0, 33'h0,                           "",         0, 1'b0);
        vecs[1] = mk("{a:3CD:1aAfF",     1'b1, {1'b0, 12'h3CD, 20'h1AAFF},      wack,       0, 1'b0);
        vecs[2] = mk("{A:3CD:ABCDE",     1'b1, {1'b1, 12'h3CD, 20'h00000},      "FFFFF\n",  1, 1'b0);
        vecs[3] = mk("{a:3G",            1'b0, 33'h0,                           "",         0, 1'b0);
        vecs[4] = mk("{A:001:00000",     1'b1, {1'b1, 12'h001, 20'h00000},      "00000\n",  0, 1'b0);
        vecs[5] = mk("{A:7fe:00000}",    1'b1, {1'b1, 12'h7FE, 20'h00000},      "12345\n",  2, 1'b1);
        vecs[6] = mk("x{A{a:0Ab:FFFFF",  1'b1, {1'b0, 12'h0AB, 20'hFFFFF},      wack,       0, 1'b1);
        vecs[7] = mk("{a:12:3",          1'b0, 33'h0,                           "",         0, 1'b1);

        repeat (3) @(negedge clk);
        check("reset_state", 64'({tx, sen, sclk, mosi, par}), 64'(5'b11000));
        rst_n = 1'b1;

        idle_ok = 1'b1;
        repeat (10000) begin
            @(negedge clk);
            if (tx !== 1'b1 || sen !== 1'b1 || sclk !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_10k", 64'(idle_ok), 64'd1);

        for (int v = 0; v < 8; v++) begin
            miso_mode = vecs[v].mode;
            if (vecs[v].mode < 2) miso = vecs[v].mode[0];
            if (vecs[v].has_spi) exp_spi_q.push_back(vecs[v].spi);
            for (int i = 0; i < vecs[v].reply.len(); i++) exp_tx_q.push_back(vecs[v].reply[i]);
            send_str(vecs[v].cmd);
            repeat (1500) @(negedge clk);
            check("pending_spi", 64'(exp_spi_q.size()), 64'd0);
            check("pending_tx", 64'(exp_tx_q.size()), 64'd0);
            check("parity", 64'(par), 64'(vecs[v].par));
        end

        // reset in the middle of a read: immediate idle outputs, no reply, parity cleared
        spi_ignore = 1'b1;
        miso_mode  = 1;
        miso       = 1'b1;
        send_str("{A:123:00000");
        n = 0;
        while ((sen !== 1'b0 || pulses < 10) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit10", 64'(n < 5000), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_outputs", 64'({sen, sclk, mosi}), 64'(3'b100));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_parity", 64'(par), 64'd0);
        repeat (2000) @(negedge clk);
        check("abort_sen_idle", 64'({sen, tx}), 64'(2'b11));
        spi_ignore = 1'b0;

        // recovery after abort
        miso_mode = 2;
        exp_spi_q.push_back({1'b1, 12'h001, 20'h00000});
        for (int i = 0; i < 6; i++) exp_tx_q.push_back(8'("12345\n" >> (8 * (5 - i))));
        send_str("{A:001:00000");
        repeat (1500) @(negedge clk);
        check("recover_pending_spi", 64'(exp_spi_q.size()), 64'd0);
        check("recover_pending_tx", 64'(exp_tx_q.size()), 64'd0);
        check("recover_parity", 64'(par), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
